// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope controller: state encoding,
// default amplitude width and the saturating arithmetic used by the FSM.
package adsr_pkg;

    localparam int AMP_W_DEF   = 10;
    localparam int AMP_MAX_DEF = (1 << AMP_W_DEF) - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // a + b clamped to lim; one extra bit keeps the carry visible
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, lim})
            return lim;
        return sum[31:0];
    endfunction

    // a - b clamped to lim from below; a start at or below lim snaps to lim
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        if (a <= lim)
            return lim;
        if ((a - lim) <= b)
            return lim;
        return a - b;
    endfunction

endpackage

// File: rtl/env_tick_gen.sv
// Free-running prescaler: one-clock tick strobe every CLKSPEED/TICK_HZ clocks.
module env_tick_gen #(
    parameter int CLKSPEED = 48_000_000,
    parameter int TICK_HZ  = 48_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int DIV   = CLKSPEED / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // wrap to zero on the tick clock, otherwise count up
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    // prescaler register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adsr_envelope_ctrl.sv
// ADSR envelope controller: synchronises the player gate, detects note-on /
// note-off edges and steps the voice amplitude once per prescaled tick.
module adsr_envelope_ctrl
    import adsr_pkg::*;
#(
    parameter int CLKSPEED = 48_000_000,
    parameter int TICK_HZ  = 48_000,
    parameter int AMP_W    = AMP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate_in,
    input  logic [AMP_W-1:0] attack_step,
    input  logic [AMP_W-1:0] decay_step,
    input  logic [AMP_W-1:0] sustain_level,
    input  logic [AMP_W-1:0] release_step,
    output logic [AMP_W-1:0] amp_out,
    output logic             retrig,
    output logic             active,
    output logic [2:0]       state_out
);

    localparam logic [AMP_W-1:0] AMP_MAX = {AMP_W{1'b1}};

    logic             tick;
    logic             gate_s1_q, gate_s2_q, gate_s3_q;
    logic             rise, fall, fall_evt, legal;
    state_t           state_q, state_d;
    logic [AMP_W-1:0] amp_q, amp_d, amp_tick;
    logic             retrig_q, retrig_d;
    logic             active_q, active_d;

    env_tick_gen #(
        .CLKSPEED (CLKSPEED),
        .TICK_HZ  (TICK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_s1_q <= 1'b0;
            gate_s2_q <= 1'b0;
            gate_s3_q <= 1'b0;
        end else begin
            gate_s1_q <= gate_in;
            gate_s2_q <= gate_s1_q;
            gate_s3_q <= gate_s2_q;
        end
    end

    assign rise     = gate_s2_q & ~gate_s3_q;
    assign fall     = ~gate_s2_q & gate_s3_q;
    assign legal    = (state_q <= ST_RELEASE);
    // note-off only matters while the note is still sounding
    assign fall_evt = fall & ((state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                              (state_q == ST_SUSTAIN));

    // amplitude the current state would move to on a tick
    always_comb begin
        amp_tick = '0;
        case (state_q)
            ST_ATTACK:  amp_tick = (attack_step == '0) ? AMP_MAX :
                            AMP_W'(sat_add(32'(amp_q), 32'(attack_step), 32'(AMP_MAX)));
            ST_DECAY:   amp_tick = (decay_step == '0) ? sustain_level :
                            AMP_W'(sat_sub(32'(amp_q), 32'(decay_step), 32'(sustain_level)));
            ST_SUSTAIN: amp_tick = sustain_level;
            ST_RELEASE: amp_tick = (release_step == '0) ? '0 :
                            AMP_W'(sat_sub(32'(amp_q), 32'(release_step), 32'd0));
            default:    amp_tick = '0;
        endcase
    end

    // state register together with the registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            amp_q    <= '0;
            retrig_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            amp_q    <= amp_d;
            retrig_q <= retrig_d;
            active_q <= active_d;
        end
    end

    // next state: edges win over the tick, segment ends when its target is reached
    always_comb begin
        state_d = state_q;
        if (!legal) begin
            state_d = ST_IDLE;
        end else if (rise) begin
            state_d = ST_ATTACK;
        end else if (fall_evt) begin
            state_d = ST_RELEASE;
        end else if (tick) begin
            case (state_q)
                ST_ATTACK:  if (amp_tick == AMP_MAX)       state_d = ST_DECAY;
                ST_DECAY:   if (amp_tick == sustain_level) state_d = ST_SUSTAIN;
                ST_RELEASE: if (amp_tick == '0)            state_d = ST_IDLE;
                default:    state_d = state_q;
            endcase
        end
    end

    // outputs: amplitude only moves on an edge-free tick, retrig marks note-on
    always_comb begin
        amp_d    = amp_q;
        retrig_d = 1'b0;
        if (!legal)
            amp_d = '0;
        else if (rise)
            retrig_d = 1'b1;
        else if (!fall_evt && tick)
            amp_d = amp_tick;
        active_d = (state_d != ST_IDLE);
    end

    assign amp_out   = amp_q;
    assign retrig    = retrig_q;
    assign active    = active_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
// Directed bench for adsr_envelope_ctrl with DIV=10; amplitude/state changes
// are checked in order against a queue of expected events.
module tb_adsr_envelope_ctrl;
    import adsr_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          gate_in;
    logic [AW-1:0] attack_step, decay_step, sustain_level, release_step;
    logic [AW-1:0] amp_out;
    logic          retrig, active;
    logic [2:0]    state_out;

    int n_total = 0;
    int n_pass = 0;
    int n_fail = 0;
    int retrig_cnt = 0;
    logic [12:0] last;
    logic [12:0] exp_q [$];

    adsr_envelope_ctrl #(
        .CLKSPEED (100),
        .TICK_HZ  (10),
        .AMP_W    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gate_in       (gate_in),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .amp_out       (amp_out),
        .retrig        (retrig),
        .active        (active),
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (retrig === 1'b1) retrig_cnt++;
    endtask

    function automatic logic [12:0] ev(input state_t s, input int a);
        return {s, a[9:0]};
    endfunction

    task automatic push(input state_t s, input int a);
        exp_q.push_back(ev(s, a));
    endtask

    // pop each expected event and wait (bounded) for the next visible change
    task automatic expect_seq(input string tag);
        logic [12:0] e, cur;
        int n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur = {state_out, amp_out};
            n = 0;
            while (cur === last && n < 40) begin
                step();
                n++;
                cur = {state_out, amp_out};
            end
            chk($sformatf("%s_state(exp a=%0d)", tag, e[9:0]), cur[12:10], e[12:10]);
            chk($sformatf("%s_amp(exp a=%0d)", tag, e[9:0]), cur[9:0], e[9:0]);
            last = cur;
        end
    endtask

    task automatic hold(input string tag, input int n);
        int changes;
        logic [12:0] cur;
        changes = 0;
        for (int i = 0; i < n; i++) begin
            step();
            cur = {state_out, amp_out};
            if (cur !== last) changes++;
            last = cur;
        end
        chk(tag, changes, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        gate_in = 1'b0;
        attack_step = 10'd256;
        decay_step = 10'd100;
        sustain_level = 10'd700;
        release_step = 10'd350;
        step();
        step();
        chk("rst_amp", amp_out, 0);
        chk("rst_state", state_out, ST_IDLE);
        chk("rst_active", active, 0);
        chk("rst_retrig", retrig, 0);
        rst = 1'b0;
        last = ev(ST_IDLE, 0);

        // note-on latency and retrig width
        gate_in = 1'b1;
        retrig_cnt = 0;
        step();
        step();
        chk("rise_early_retrig", retrig, 0);
        chk("rise_early_state", state_out, ST_IDLE);
        step();
        chk("rise_retrig", retrig, 1);
        chk("rise_state", state_out, ST_ATTACK);
        chk("rise_active", active, 1);
        chk("rise_amp", amp_out, 0);
        step();
        chk("retrig_width", retrig, 0);
        last = ev(ST_ATTACK, 0);

        // full attack / decay into sustain
        push(ST_ATTACK, 256); push(ST_ATTACK, 512); push(ST_ATTACK, 768);
        push(ST_DECAY, AMP_MAX_DEF); push(ST_DECAY, 923); push(ST_DECAY, 823);
        push(ST_DECAY, 723); push(ST_SUSTAIN, 700);
        expect_seq("env");
        hold("sustain_hold", 25);
        chk("sustain_amp", amp_out, 700);
        chk("env_retrig_cnt", retrig_cnt, 1);

        // release to idle
        gate_in = 1'b0;
        push(ST_RELEASE, 700); push(ST_RELEASE, 350); push(ST_IDLE, 0);
        expect_seq("rel");
        chk("rel_active", active, 0);
        hold("idle_hold", 15);

        // second note, then retrigger during release at 350
        gate_in = 1'b1;
        push(ST_ATTACK, 0); push(ST_ATTACK, 256); push(ST_ATTACK, 512);
        push(ST_ATTACK, 768); push(ST_DECAY, AMP_MAX_DEF); push(ST_DECAY, 923);
        push(ST_DECAY, 823); push(ST_DECAY, 723); push(ST_SUSTAIN, 700);
        expect_seq("env2");
        gate_in = 1'b0;
        push(ST_RELEASE, 700); push(ST_RELEASE, 350);
        expect_seq("rel2");
        retrig_cnt = 0;
        gate_in = 1'b1;
        push(ST_ATTACK, 350); push(ST_ATTACK, 606); push(ST_ATTACK, 862);
        push(ST_DECAY, AMP_MAX_DEF); push(ST_DECAY, 923); push(ST_DECAY, 823);
        push(ST_DECAY, 723); push(ST_SUSTAIN, 700);
        expect_seq("retrig");
        chk("retrig_cnt", retrig_cnt, 1);
        gate_in = 1'b0;
        push(ST_RELEASE, 700); push(ST_RELEASE, 350); push(ST_IDLE, 0);
        expect_seq("rel3");

        // zero steps jump straight to each segment target
        attack_step = '0;
        decay_step = '0;
        release_step = '0;
        gate_in = 1'b1;
        push(ST_ATTACK, 0); push(ST_DECAY, AMP_MAX_DEF); push(ST_SUSTAIN, 700);
        expect_seq("zero_ad");
        gate_in = 1'b0;
        push(ST_RELEASE, 700); push(ST_IDLE, 0);
        expect_seq("zero_r");
        attack_step = 10'd256;
        decay_step = 10'd100;
        release_step = 10'd350;

        // rise lands on the tick clock: edge wins, increment waits a full tick
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        gate_in = 1'b1;
        step();
        step();
        chk("coll_pre_state", state_out, ST_IDLE);
        step();
        chk("coll_state", state_out, ST_ATTACK);
        chk("coll_amp", amp_out, 0);
        for (int i = 0; i < 9; i++) step();
        chk("coll_amp_hold", amp_out, 0);
        step();
        chk("coll_first_inc", amp_out, 256);
        for (int i = 0; i < 10; i++) step();
        chk("pre_rst_amp", amp_out, 512);

        // asynchronous reset mid-attack, gate held high throughout
        #2 rst = 1'b1;
        #1;
        chk("midrst_amp", amp_out, 0);
        chk("midrst_state", state_out, ST_IDLE);
        chk("midrst_active", active, 0);
        chk("midrst_retrig", retrig, 0);
        step();
        step();
        rst = 1'b0;
        retrig_cnt = 0;
        step();
        step();
        chk("postrst_early_retrig", retrig, 0);
        chk("postrst_early_state", state_out, ST_IDLE);
        step();
        chk("postrst_retrig", retrig, 1);
        chk("postrst_state", state_out, ST_ATTACK);
        step();
        chk("postrst_retrig_cnt", retrig_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
